// File: rtl/lut_product_search_pkg.sv
// -----------------------------------------------------------------------------
// lut_product_search_pkg
// Shared definitions for the reverse product lookup (value -> index search):
//   - product field widths (X is 1 bit, Y is 2 bits, product is 3 bits)
//   - packed product type used for both table entries and the search key
//   - FSM state encoding for the search controller
//   - a small helper that builds a product from its fields
// -----------------------------------------------------------------------------
package lut_product_search_pkg;

    localparam int X_W       = 1;
    localparam int Y_W       = 2;
    localparam int PRODUCT_W = X_W + Y_W;

    // One table entry / search key: {X, Y}
    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } product_t;

    // Search controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_e;

    // Build a product value from its two fields
    function automatic product_t make_product(input logic [X_W-1:0] x,
                                              input logic [Y_W-1:0] y);
        product_t p;
        p.x = x;
        p.y = y;
        return p;
    endfunction

endpackage

// File: rtl/lut_product_table.sv
// -----------------------------------------------------------------------------
// lut_product_table
// Register-based table of 2**N product entries with one synchronous write port
// and one combinational read port.  Synchronous reset reloads every entry from
// INIT, where entry i has X = INIT[3i] and Y = INIT[3i+2:3i+1].
//
// Ports:
//   clk       in   clock, all updates on rising edge
//   reset     in   synchronous active-high reset (reload from INIT)
//   wr_en     in   write strobe, entry[wr_idx] <= wr_entry at the edge
//   wr_idx    in   N-bit write index
//   wr_entry  in   product to store
//   rd_idx    in   N-bit read index
//   rd_entry  out  entry[rd_idx], combinational
// -----------------------------------------------------------------------------
module lut_product_table
    import lut_product_search_pkg::*;
#(
    parameter int                            N    = 1,
    parameter logic [PRODUCT_W*(2**N)-1:0]   INIT = '0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           wr_en,
    input  logic [N-1:0]   wr_idx,
    input  product_t       wr_entry,
    input  logic [N-1:0]   rd_idx,
    output product_t       rd_entry
);

    localparam int DEPTH = 2**N;

    product_t table_r [DEPTH];

    // Table storage: reload from INIT on reset, otherwise accept writes
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_r[i].x <= INIT[PRODUCT_W*i +: X_W];
                table_r[i].y <= INIT[PRODUCT_W*i+X_W +: Y_W];
            end
        end else if (wr_en) begin
            table_r[wr_idx] <= wr_entry;
        end
    end

    assign rd_entry = table_r[rd_idx];

endmodule

// File: rtl/lut_product_search.sv
// -----------------------------------------------------------------------------
// lut_product_search
// Inverse of a product LUT: given a product {X, Y}, scans the table from
// index 0 upward, one entry per cycle, and reports the lowest index holding
// that product (hit) or a miss after the last entry.
//
// Ports:
//   CLK       in   clock
//   RESET     in   synchronous active-high reset (also reloads the table)
//   WR_VALID  in   write request       WR_READY out  high only in IDLE
//   WR_IDX    in   write index (N)     WR_X/WR_Y in  product to store
//   Q_VALID   in   query request       Q_READY  out  high only in IDLE
//   Q_X/Q_Y   in   search key
//   R_VALID   out  result valid (RESP only), held until R_READY
//   R_HIT     out  1 = key found       R_IDX    out  lowest matching index
//   R_READY   in   result consumed when R_VALID & R_READY
// -----------------------------------------------------------------------------
module lut_product_search
    import lut_product_search_pkg::*;
#(
    parameter int                            N    = 1,
    parameter logic [PRODUCT_W*(2**N)-1:0]   INIT = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             WR_VALID,
    input  logic [N-1:0]     WR_IDX,
    input  logic [X_W-1:0]   WR_X,
    input  logic [Y_W-1:0]   WR_Y,
    output logic             WR_READY,
    input  logic             Q_VALID,
    input  logic [X_W-1:0]   Q_X,
    input  logic [Y_W-1:0]   Q_Y,
    output logic             Q_READY,
    output logic             R_VALID,
    output logic             R_HIT,
    output logic [N-1:0]     R_IDX,
    input  logic             R_READY
);

    localparam logic [N-1:0] PTR_MAX = {N{1'b1}};

    state_e         state_r;
    state_e         state_s;
    product_t       key_r;
    product_t       key_s;
    logic [N-1:0]   ptr_r;
    logic [N-1:0]   ptr_s;
    logic           hit_r;
    logic           hit_s;
    logic [N-1:0]   idx_r;
    logic [N-1:0]   idx_s;
    logic           r_valid_r;
    logic           idle_r;
    logic           wr_en_s;
    logic           match_s;
    product_t       rd_entry_s;

    // Writes are only taken while idle; a write and a query accepted on the
    // same edge both land at that edge, so the scan sees the new entry.
    assign wr_en_s = WR_VALID & (state_r == IDLE);

    lut_product_table #(
        .N    (N),
        .INIT (INIT)
    ) u_table (
        .clk      (CLK),
        .reset    (RESET),
        .wr_en    (wr_en_s),
        .wr_idx   (WR_IDX),
        .wr_entry (make_product(WR_X, WR_Y)),
        .rd_idx   (ptr_r),
        .rd_entry (rd_entry_s)
    );

    assign match_s = (rd_entry_s == key_r);

    // Next-state and datapath decode for the search controller
    always_comb begin
        state_s = state_r;
        key_s   = key_r;
        ptr_s   = ptr_r;
        hit_s   = hit_r;
        idx_s   = idx_r;
        case (state_r)
            IDLE: begin
                if (Q_VALID) begin
                    key_s   = make_product(Q_X, Q_Y);
                    ptr_s   = '0;
                    state_s = SCAN;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (match_s) begin
                    hit_s   = 1'b1;
                    idx_s   = ptr_r;
                    state_s = RESP;
                end else if (ptr_r == PTR_MAX) begin
                    // Last entry checked without a match: report a miss,
                    // the pointer never wraps back to 0.
                    hit_s   = 1'b0;
                    idx_s   = '0;
                    state_s = RESP;
                end else begin
                    ptr_s   = ptr_r + N'(1);
                    state_s = SCAN;
                end
            end
            RESP: begin
                if (R_READY) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Controller registers; handshake flags are registered from the next
    // state so they always agree with state_r.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r   <= IDLE;
            key_r     <= '0;
            ptr_r     <= '0;
            hit_r     <= 1'b0;
            idx_r     <= '0;
            r_valid_r <= 1'b0;
            idle_r    <= 1'b1;
        end else begin
            state_r   <= state_s;
            key_r     <= key_s;
            ptr_r     <= ptr_s;
            hit_r     <= hit_s;
            idx_r     <= idx_s;
            r_valid_r <= (state_s == RESP);
            idle_r    <= (state_s == IDLE);
        end
    end

    assign WR_READY = idle_r;
    assign Q_READY  = idle_r;
    assign R_VALID  = r_valid_r;
    assign R_HIT    = hit_r;
    assign R_IDX    = idx_r;

endmodule

// File: tb/tb_lut_product_search.sv
// -----------------------------------------------------------------------------
// tb_lut_product_search
// Directed bench for lut_product_search with N=1.  dut uses INIT=0, dut2 uses
// INIT=6'b011_011 (both entries X=1 Y=1).  Latency is counted in rising edges
// after the query-accept edge until R_VALID is seen: a match at index k gives
// k+1 edges, a miss gives 2**N = 2 edges.
// -----------------------------------------------------------------------------
module tb_lut_product_search;

    logic       clk = 1'b0;
    logic       rst, wr_valid, wr_x, q_valid, q_x, r_ready;
    logic [0:0] wr_idx;
    logic [1:0] wr_y, q_y;
    logic       wr_ready, q_ready, r_valid, r_hit;
    logic [0:0] r_idx;

    logic       rst2, q_valid2, q_x2, r_ready2;
    logic [1:0] q_y2;
    logic       wr_valid2, wr_x2;
    logic [0:0] wr_idx2;
    logic [1:0] wr_y2;
    logic       wr_ready2, q_ready2, r_valid2, r_hit2;
    logic [0:0] r_idx2;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    lut_product_search #(.N(1), .INIT(6'b000_000)) dut (
        .CLK(clk), .RESET(rst),
        .WR_VALID(wr_valid), .WR_IDX(wr_idx), .WR_X(wr_x), .WR_Y(wr_y), .WR_READY(wr_ready),
        .Q_VALID(q_valid), .Q_X(q_x), .Q_Y(q_y), .Q_READY(q_ready),
        .R_VALID(r_valid), .R_HIT(r_hit), .R_IDX(r_idx), .R_READY(r_ready)
    );

    lut_product_search #(.N(1), .INIT(6'b011_011)) dut2 (
        .CLK(clk), .RESET(rst2),
        .WR_VALID(wr_valid2), .WR_IDX(wr_idx2), .WR_X(wr_x2), .WR_Y(wr_y2), .WR_READY(wr_ready2),
        .Q_VALID(q_valid2), .Q_X(q_x2), .Q_Y(q_y2), .Q_READY(q_ready2),
        .R_VALID(r_valid2), .R_HIT(r_hit2), .R_IDX(r_idx2), .R_READY(r_ready2)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; wr_valid = 1'b0; q_valid = 1'b0; r_ready = 1'b0;
        wr_idx = 1'b0; wr_x = 1'b0; wr_y = 2'd0; q_x = 1'b0; q_y = 2'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_write(input logic idx, input logic x, input logic [1:0] y);
        @(negedge clk);
        wr_valid = 1'b1; wr_idx = idx; wr_x = x; wr_y = y;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Issue a query, wait for the result, check it, then consume it
    task automatic do_query(input logic x, input logic [1:0] y, input logic eh,
                            input logic ei, input int el, input string nm);
        int lat;
        @(negedge clk);
        checks++;
        if (q_ready !== 1'b1) begin
            fails++; $display("FAIL %s q_ready: got %b want 1", nm, q_ready);
        end
        q_valid = 1'b1; q_x = x; q_y = y;
        @(negedge clk);
        q_valid = 1'b0;
        lat = 0;
        while (r_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != el) begin
            fails++; $display("FAIL %s latency: got %0d want %0d", nm, lat, el);
        end
        checks++;
        if (r_hit !== eh) begin
            fails++; $display("FAIL %s r_hit: got %b want %b", nm, r_hit, eh);
        end
        checks++;
        if (r_idx !== ei) begin
            fails++; $display("FAIL %s r_idx: got %b want %b", nm, r_idx, ei);
        end
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        checks++;
        if (r_valid !== 1'b0 || q_ready !== 1'b1) begin
            fails++; $display("FAIL %s release: got r_valid=%b q_ready=%b want 0/1", nm, r_valid, q_ready);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; wr_valid = 1'b0; q_valid = 1'b0; r_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (q_ready !== 1'b1 || wr_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready: got q=%b wr=%b want 1/1", q_ready, wr_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (r_valid !== 1'b0 || r_hit !== 1'b0 || r_idx !== 1'b0) begin
            fails++; $display("FAIL reset_outputs: got v=%b h=%b i=%b want 0/0/0", r_valid, r_hit, r_idx);
        end
    endtask

    task automatic test_basic_hit();
        do_query(1'b0, 2'd0, 1'b1, 1'b0, 1, "hit_idx0");
    endtask

    task automatic test_write_hit();
        do_write(1'b1, 1'b1, 2'd2);
        do_query(1'b1, 2'd2, 1'b1, 1'b1, 2, "hit_idx1");
    endtask

    task automatic test_miss();
        do_reset();
        do_query(1'b1, 2'd3, 1'b0, 1'b0, 2, "miss");
    endtask

    task automatic test_duplicates();
        do_reset();
        do_write(1'b1, 1'b0, 2'd0);
        do_query(1'b0, 2'd0, 1'b1, 1'b0, 1, "dup_lowest");
        do_write(1'b0, 1'b1, 2'd1);
        do_query(1'b0, 2'd0, 1'b1, 1'b1, 2, "dup_after_overwrite");
    endtask

    task automatic test_hold();
        int lat;
        do_reset();
        @(negedge clk);
        q_valid = 1'b1; q_x = 1'b0; q_y = 2'd0;
        @(negedge clk);
        q_valid = 1'b0;
        lat = 0;
        while (r_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (r_valid !== 1'b1 || r_hit !== 1'b1 || r_idx !== 1'b0) begin
                fails++; $display("FAIL hold_result c%0d: got v=%b h=%b i=%b want 1/1/0", c, r_valid, r_hit, r_idx);
            end
            checks++;
            if (q_ready !== 1'b0 || wr_ready !== 1'b0) begin
                fails++; $display("FAIL hold_ready c%0d: got q=%b wr=%b want 0/0", c, q_ready, wr_ready);
            end
            wr_valid = 1'b1; wr_idx = 1'b0; wr_x = 1'b1; wr_y = 2'd3;
            q_valid = 1'b1; q_x = 1'b1; q_y = 2'd3;
            @(negedge clk);
        end
        wr_valid = 1'b0; q_valid = 1'b0;
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        do_query(1'b1, 2'd3, 1'b0, 1'b0, 2, "hold_table_unchanged");
        do_query(1'b0, 2'd0, 1'b1, 1'b0, 1, "hold_entry0_intact");
    endtask

    task automatic test_same_edge();
        int lat;
        do_reset();
        @(negedge clk);
        wr_valid = 1'b1; wr_idx = 1'b0; wr_x = 1'b1; wr_y = 2'd1;
        q_valid = 1'b1; q_x = 1'b1; q_y = 2'd1;
        @(negedge clk);
        wr_valid = 1'b0; q_valid = 1'b0;
        lat = 0;
        while (r_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 1 || r_hit !== 1'b1 || r_idx !== 1'b0) begin
            fails++; $display("FAIL same_edge: got lat=%0d h=%b i=%b want 1/1/0", lat, r_hit, r_idx);
        end
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
    endtask

    task automatic test_reset_mid_resp();
        int lat;
        do_reset();
        @(negedge clk);
        q_valid = 1'b1; q_x = 1'b0; q_y = 2'd0;
        @(negedge clk);
        q_valid = 1'b0;
        lat = 0;
        while (r_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (r_valid !== 1'b0 || r_hit !== 1'b0 || q_ready !== 1'b1) begin
            fails++; $display("FAIL reset_mid_resp: got v=%b h=%b q=%b want 0/0/1", r_valid, r_hit, q_ready);
        end
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        wr_valid2 = 1'b0; wr_idx2 = 1'b0; wr_x2 = 1'b0; wr_y2 = 2'd0;
        q_valid2 = 1'b0; q_x2 = 1'b0; q_y2 = 2'd0; r_ready2 = 1'b0;
        rst2 = 1'b1;
        repeat (2) @(negedge clk);
        rst2 = 1'b0;
        // Query a missing key so the scan is still running when reset hits
        @(negedge clk);
        q_valid2 = 1'b1; q_x2 = 1'b0; q_y2 = 2'd0;
        @(negedge clk);
        q_valid2 = 1'b0;
        rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        checks++;
        if (r_valid2 !== 1'b0 || q_ready2 !== 1'b1) begin
            fails++; $display("FAIL mid_scan_reset: got v=%b q=%b want 0/1", r_valid2, q_ready2);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (r_valid2 !== 1'b0) begin
            fails++; $display("FAIL mid_scan_no_resp: got v=%b want 0", r_valid2);
        end
        q_valid2 = 1'b1; q_x2 = 1'b1; q_y2 = 2'd1;
        @(negedge clk);
        q_valid2 = 1'b0;
        lat = 0;
        while (r_valid2 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 1 || r_hit2 !== 1'b1 || r_idx2 !== 1'b0) begin
            fails++; $display("FAIL init_hit: got lat=%0d h=%b i=%b want 1/1/0", lat, r_hit2, r_idx2);
        end
        r_ready2 = 1'b1;
        @(negedge clk);
        r_ready2 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; q_valid = 1'b0; r_ready = 1'b0;
        wr_idx = 1'b0; wr_x = 1'b0; wr_y = 2'd0; q_x = 1'b0; q_y = 2'd0;
        rst2 = 1'b1; wr_valid2 = 1'b0; q_valid2 = 1'b0; r_ready2 = 1'b0;
        wr_idx2 = 1'b0; wr_x2 = 1'b0; wr_y2 = 2'd0; q_x2 = 1'b0; q_y2 = 2'd0;
        test_reset();
        test_basic_hit();
        test_write_hit();
        test_miss();
        test_duplicates();
        test_hold();
        test_same_edge();
        test_reset_mid_resp();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/lut_product_search.md
LUT_PRODUCT_SEARCH -- requirements
Module: lut_product_search

Interface
REQ-001 SHALL have parameter N, default 1: index width; table depth = 2**N entries.
REQ-002 SHALL have parameter INIT, default 0, width 3*2**N: reset contents; entry i X = INIT[3i], Y = INIT[3i+2:3i+1].
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports WR_VALID in 1, WR_IDX in N, WR_X in 1, WR_Y in 2: entry write request.
REQ-006 SHALL have port WR_READY, output, 1 bit: write accepted when WR_VALID & WR_READY.
REQ-007 SHALL have ports Q_VALID in 1, Q_X in 1, Q_Y in 2: search key, a product {X, Y}.
REQ-008 SHALL have port Q_READY, output, 1 bit: query accepted when Q_VALID & Q_READY.
REQ-009 SHALL have ports R_VALID out 1, R_HIT out 1, R_IDX out N: search result.
REQ-010 SHALL have port R_READY, input, 1 bit: result consumed when R_VALID & R_READY.

Function
REQ-011 SHALL hold a table of 2**N entries of product {X:1, Y:2} in registers; this is the inverse of the product LUT (value -> index).
REQ-012 SHALL implement FSM states IDLE, SCAN, RESP.
REQ-013 SHALL assert Q_READY and WR_READY only in IDLE; R_VALID only in RESP.
REQ-014 IDLE: on query accept, latch {Q_X, Q_Y} as key, clear scan pointer to 0, go to SCAN.
REQ-015 SCAN: each cycle compare entry[ptr] with key, both X and Y equal = match.
REQ-016 SCAN match: register R_HIT=1, R_IDX=ptr, go to RESP.
REQ-017 SCAN no match with ptr < 2**N-1: increment ptr, stay in SCAN.
REQ-018 SCAN no match at ptr = 2**N-1: register R_HIT=0, R_IDX=0, go to RESP; pointer never wraps.
REQ-019 Duplicate entries: lowest matching index SHALL be reported.
REQ-020 Latency: query accepted at edge t; match at index k gives R_VALID high from cycle t+2+k; miss gives R_VALID from t+1+2**N.
REQ-021 RESP: R_VALID, R_HIT and R_IDX SHALL stay stable until R_READY; on R_VALID & R_READY return to IDLE. Next query is accepted no earlier than the following cycle.
REQ-022 Write accept SHALL update entry[WR_IDX] at that edge.
REQ-023 Write and query accepted at the same edge: the write SHALL be visible to the scan that follows.
REQ-024 WR_VALID or Q_VALID outside IDLE SHALL be ignored and SHALL have no side effects.

Reset
REQ-025 RESET high at an edge SHALL force IDLE, R_VALID=0, R_HIT=0, R_IDX=0, clear the pointer and key, and reload the table from INIT.
REQ-026 RESET SHALL take priority over any write, query or response in the same cycle, including mid-SCAN and mid-RESP.
REQ-027 During reset Q_READY and WR_READY SHALL read per the IDLE state only after the reset edge.

Structure
REQ-028 Shared package SHALL define the product field widths (X=1, Y=2, PRODUCT_W=3) and the FSM state encoding.
REQ-029 Table storage and write port SHALL be one sub-module, lut_product_table, with one combinational read port addressed by the scan pointer.
REQ-030 FSM, key register and comparator SHALL live in lut_product_search.

Verification (N=1, INIT=0 unless stated)
REQ-031 Reset, then query X=0 Y=0 -> R_VALID at t+2, R_HIT=1, R_IDX=0.
REQ-032 Write idx1 X=1 Y=2, then query X=1 Y=2 -> R_VALID at t+3, R_HIT=1, R_IDX=1.
REQ-033 Query X=1 Y=3 on the default table -> R_VALID at t+3, R_HIT=0, R_IDX=0.
REQ-034 Hold R_READY=0 for 5 cycles in RESP -> outputs stable, Q_READY=WR_READY=0, extra WR_VALID pulses leave the table unchanged.
REQ-035 Same-edge write idx0 X=1 Y=1 and query X=1 Y=1 -> R_HIT=1, R_IDX=0.
REQ-036 Use INIT=6'b011_011 and assert RESET mid-SCAN -> next cycle IDLE, R_VALID=0; a fresh query X=1 Y=1 returns R_HIT=1, R_IDX=0.
